// File: rtl/instr_encoder.sv
// instr_encoder
// Encodes decoded MIPS instruction fields into 32-bit words and writes them to
// consecutive instruction-memory addresses, starting at 0. It is used to
// preload a program before the core leaves reset.
//
// Ports:
//   clk, rst_n      rising-edge clock, synchronous active-low reset
//   clear           restart loading at address 0 (leaves DONE/FULL)
//   in_valid/ready  field-bundle handshake; in_last marks the final bundle
//   in_kind         0=R-type 1=lw 2=sw 3=beq 4=addi (5-7 illegal)
//   in_rs/rt/rd/shamt/funct/imm  instruction fields
//   wr_en/addr/data instruction-memory write port (one cycle after accept)
//   count           words written since reset/clear
//   err             one-cycle pulse when an illegal bundle was rejected
//   done, full      load finished by in_last / memory filled
//
// state | meaning
// LOAD  | accepting bundles, ptr is the next free address
// FULL  | DEPTH words written without in_last; held until clear/reset
// DONE  | in_last accepted; held until clear/reset
module instr_encoder #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [2:0]            in_kind,
  input  logic [4:0]            in_rs,
  input  logic [4:0]            in_rt,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_shamt,
  input  logic [5:0]            in_funct,
  input  logic [15:0]           in_imm,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  err,
  output logic                  done,
  output logic                  full
);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_FULL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]           wr_data_q, wr_data_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  err_q, err_d;

  logic        accept;
  logic        legal;
  logic [5:0]  opcode;
  logic [31:0] word;

  assign in_ready = (state_q == S_LOAD) && !clear && rst_n;
  assign accept   = in_valid && in_ready;

  // Field encoder; legality covers both the kind and, for R-type, the funct.
  always_comb begin
    legal  = 1'b1;
    opcode = 6'b000000;
    case (in_kind)
      3'd0: begin
        case (in_funct)
          6'b100000, 6'b100010, 6'b100100,
          6'b100101, 6'b101010, 6'b100111: legal = 1'b1;
          default:                         legal = 1'b0;
        endcase
      end
      3'd1:    opcode = 6'b100011;
      3'd2:    opcode = 6'b101011;
      3'd3:    opcode = 6'b000100;
      3'd4:    opcode = 6'b001000;
      default: legal  = 1'b0;
    endcase
    if (in_kind == 3'd0) begin
      word = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
    end else begin
      word = {opcode, in_rs, in_rt, in_imm};
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = 1'b0;
    // count tracks completed writes, so it follows wr_en by one edge.
    count_d   = count_q + (ADDR_WIDTH+1)'(wr_en_q);
    if (clear) begin
      state_d = S_LOAD;
      ptr_d   = '0;
      count_d = '0;
    end else if (accept) begin
      if (legal) begin
        wr_en_d   = 1'b1;
        wr_addr_d = ptr_q;
        wr_data_d = word;
        ptr_d     = ptr_q + ADDR_WIDTH'(1);
      end else begin
        err_d = 1'b1;
      end
      // in_last wins over the DEPTH-th word; ptr wrapping to 0 is harmless
      // because FULL/DONE block further accepts until clear resets ptr.
      if (in_last) begin
        state_d = S_DONE;
      end else if (legal && (ptr_q == '1)) begin
        state_d = S_FULL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_LOAD;
      ptr_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

  // A write pending while reset is asserted is dropped rather than issued.
  assign wr_en   = wr_en_q && rst_n;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign count   = count_q;
  assign err     = err_q;
  assign done    = (state_q == S_DONE);
  assign full    = (state_q == S_FULL);

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0, clear = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [2:0]    in_kind = '0;
  logic [4:0]    in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [5:0]    in_funct = '0;
  logic [15:0]   in_imm = '0;
  logic          in_ready, wr_en, err, done, full;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [AW:0]   count;

  instr_encoder #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .count(count), .err(err), .done(done), .full(full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          op_tab[5]    = '{0, 35, 43, 4, 8};
  int          funct_ok[6]  = '{32, 34, 36, 37, 42, 39};
  int          m_state = 0;   // 0 loading, 1 full, 2 done
  int          m_ptr = 0;
  int          m_count = 0;
  bit          m_wr_en = 0, m_err = 0;
  int          m_addr = 0;
  logic [31:0] m_data = '0;

  function automatic void model_encode(output bit lg, output logic [31:0] w);
    int k;
    k  = int'(in_kind);
    lg = 0;
    w  = '0;
    if (k == 0) begin
      foreach (funct_ok[i]) if (int'(in_funct) == funct_ok[i]) lg = 1;
      w = in_rs * 32'h0020_0000 + in_rt * 32'h0001_0000 + in_rd * 32'h0000_0800
        + in_shamt * 32'h40 + in_funct;
    end else if (k <= 4) begin
      lg = 1;
      w = op_tab[k] * 32'h0400_0000 + in_rs * 32'h0020_0000 + in_rt * 32'h0001_0000 + in_imm;
    end
  endfunction

  always @(posedge clk) begin : model
    bit          acc, lg;
    logic [31:0] w;
    if (!rst_n) begin
      m_state = 0; m_ptr = 0; m_count = 0; m_wr_en = 0; m_err = 0;
      m_addr = 0; m_data = '0;
    end else begin
      m_count = clear ? 0 : m_count + int'(m_wr_en);
      acc     = in_valid && (m_state == 0) && !clear;
      m_wr_en = 0;
      m_err   = 0;
      if (clear) begin
        m_state = 0;
        m_ptr   = 0;
      end else if (acc) begin
        model_encode(lg, w);
        if (lg) begin
          m_wr_en = 1; m_addr = m_ptr; m_data = w; m_ptr++;
        end else begin
          m_err = 1;
        end
        if (in_last) m_state = 2;
        else if (lg && m_ptr == DEPTH) m_state = 1;
      end
    end
  end

  logic [31:0] log_a[$];
  logic [31:0] log_d[$];
  int          err_pulses = 0;

  always @(negedge clk) begin : compare
    chk("in_ready", 32'(in_ready), 32'((m_state == 0) && !clear && rst_n));
    chk("wr_en", 32'(wr_en), 32'(m_wr_en && rst_n));
    if (m_wr_en && rst_n) begin
      chk("wr_addr", 32'(wr_addr), 32'(m_addr));
      chk("wr_data", wr_data, m_data);
    end
    chk("count", 32'(count), 32'(m_count));
    chk("err", 32'(err), 32'(m_err));
    chk("done", 32'(done), 32'(m_state == 2));
    chk("full", 32'(full), 32'(m_state == 1));
    if (wr_en === 1'b1) begin
      log_a.push_back(32'(wr_addr));
      log_d.push_back(wr_data);
    end
    if (err === 1'b1) err_pulses++;
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
  endtask

  task automatic set_fields(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [5:0] f, input logic [15:0] imm,
                            input logic last);
    in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = '0;
    in_funct = f; in_imm = imm; in_last = last;
  endtask

  task automatic send(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [5:0] f, input logic [15:0] imm,
                      input logic last);
    bit got;
    got = 0;
    set_fields(k, rs, rt, rd, f, imm, last);
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL send_timeout: got no in_ready expected accept within 20 cycles");
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  int base;
  int ep0;

  initial begin
    // Reset
    idle(2);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_wr_addr", 32'(wr_addr), 32'd0);
    chk("reset_wr_data", wr_data, 32'd0);
    chk("reset_count", 32'(count), 32'd0);

    // add $3,$1,$2
    base = log_d.size();
    send(3'd0, 5'd1, 5'd2, 5'd3, 6'b100000, 16'h0, 1'b0);
    idle(2);
    chk("add_data", log_d[base], 32'h0022_1820);
    chk("add_addr", log_a[base], 32'd0);
    chk("add_count", 32'(count), 32'd1);

    // back-to-back program ending with in_last on the DEPTH-th word
    do_clear();
    base = log_d.size();
    send(3'd1, 5'd9, 5'd8, 5'd0, 6'd0, 16'h0004, 1'b0);
    send(3'd2, 5'd9, 5'd8, 5'd0, 6'd0, 16'h0004, 1'b0);
    send(3'd3, 5'd1, 5'd2, 5'd0, 6'd0, 16'hFFFF, 1'b0);
    send(3'd4, 5'd0, 5'd2, 5'd0, 6'd0, 16'h0005, 1'b1);
    idle(2);
    chk("lw_data", log_d[base], 32'h8D28_0004);
    chk("sw_data", log_d[base+1], 32'hAD28_0004);
    chk("beq_data", log_d[base+2], 32'h1022_FFFF);
    chk("addi_data", log_d[base+3], 32'h2002_0005);
    chk("addi_addr", log_a[base+3], 32'd3);
    chk("prog_done", 32'(done), 32'd1);
    chk("prog_full", 32'(full), 32'd0);
    chk("prog_ready", 32'(in_ready), 32'd0);

    // illegal bundles, then a legal one
    do_clear();
    base = log_d.size();
    ep0  = err_pulses;
    send(3'd6, 5'd1, 5'd2, 5'd3, 6'b100000, 16'h0, 1'b0);
    send(3'd0, 5'd1, 5'd2, 5'd3, 6'b000000, 16'h0, 1'b0);
    idle(2);
    chk("illegal_writes", 32'(log_d.size() - base), 32'd0);
    chk("illegal_err_pulses", 32'(err_pulses - ep0), 32'd2);
    chk("illegal_count", 32'(count), 32'd0);
    send(3'd0, 5'd4, 5'd5, 5'd6, 6'b101010, 16'h0, 1'b0);
    idle(2);
    chk("after_illegal_addr", log_a[base], 32'd0);
    chk("after_illegal_data", log_d[base], 32'h0085_302A);
    chk("after_illegal_count", 32'(count), 32'd1);

    // illegal bundle carrying in_last still finishes the load
    send(3'd7, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 1'b1);
    idle(2);
    chk("illegal_last_done", 32'(done), 32'd1);

    // fill memory without in_last
    do_clear();
    for (int i = 0; i < DEPTH; i++)
      send(3'd0, 5'd1, 5'd2, 5'(i), 6'b100100, 16'h0, 1'b0);
    idle(1);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ready", 32'(in_ready), 32'd0);
    chk("fill_count", 32'(count), 32'd4);
    base = log_d.size();
    set_fields(3'd1, 5'd1, 5'd1, 5'd0, 6'd0, 16'h0, 1'b1);
    in_valid = 1'b1;
    idle(3);
    in_valid = 1'b0;
    in_last  = 1'b0;
    idle(1);
    chk("full_ignores_valid", 32'(log_d.size() - base), 32'd0);
    chk("full_held", 32'(full), 32'd1);
    do_clear();
    send(3'd4, 5'd3, 5'd4, 5'd0, 6'd0, 16'h1234, 1'b0);
    idle(1);
    chk("refill_addr", log_a[log_a.size()-1], 32'd0);

    // clear pulse while in_valid is held
    do_clear();
    base = log_d.size();
    set_fields(3'd0, 5'd7, 5'd8, 5'd9, 6'b100101, 16'h0, 1'b0);
    in_valid = 1'b1;
    idle(2);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    chk("clear_count_zero", 32'(count), 32'd0);
    idle(1);
    in_valid = 1'b0;
    idle(2);
    chk("clear_stream_writes", 32'(log_d.size() - base), 32'd3);
    chk("clear_stream_addr", log_a[base+2], 32'd0);
    chk("clear_stream_count", 32'(count), 32'd1);

    // reset right after an accept
    do_clear();
    send(3'd0, 5'd1, 5'd2, 5'd3, 6'b100010, 16'h0, 1'b0);
    base = log_d.size();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_drop_wr_en", 32'(wr_en), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_mid_count", 32'(count), 32'd0);
    chk("rst_mid_addr", 32'(wr_addr), 32'd0);
    chk("rst_mid_data", wr_data, 32'd0);
    send(3'd2, 5'd2, 5'd3, 5'd0, 6'd0, 16'h0010, 1'b0);
    idle(2);
    chk("rst_dropped_write", 32'(log_d.size() - base), 32'd1);
    chk("post_rst_addr", log_a[base], 32'd0);
    chk("post_rst_data", log_d[base], 32'hAC43_0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
